// File: rtl/series_datapath_if.sv
// Control/status bus between the series FSM controller (master) and the datapath (slave).
// Latency: none; this is a bundle of wires only.
// Backpressure: none; the controller issues one command set per clock and the datapath always accepts it.
interface series_datapath_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    // operands and threshold
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    // register-transfer commands
    logic             initt;
    logic             initr;
    logic             initc;
    logic             ld_x;
    logic             ld_y;
    logic             ld_t;
    logic             ld_r;
    logic             cnt;
    logic             s2;
    logic             s1;
    logic             s0;
    logic             mode;
    // status back to the controller / observers
    logic             lt;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] count;

    modport master (
        output x_in, y_in, initt, initr, initc, ld_x, ld_y, ld_t, ld_r, cnt,
               s2, s1, s0, mode,
        input  lt, result, count
    );

    modport slave (
        input  x_in, y_in, initt, initr, initc, ld_x, ld_y, ld_t, ld_r, cnt,
               s2, s1, s0, mode,
        output lt, result, count
    );
endinterface

// File: rtl/series_datapath.sv
// Series engine datapath: x, y, term t, accumulator r, counter c; one register transfer per clock.
// Latency: result/count update 1 cycle after ld_r/cnt; lt is combinational from the registers.
// Backpressure: none; every command is executed on the edge it is presented. SERIES_SAT_EN selects saturation.
module series_datapath #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CNT_W    = 4,
    parameter int MAX_ITER = 15
) (
    input  logic         clk,
    input  logic         rst,
    series_datapath_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] r;
    logic [CNT_W-1:0] c;

    logic [2:0]       sel;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] prod_val;
    logic [WIDTH-1:0] sum_val;

    assign sel = {bus.s2, bus.s1, bus.s0};

    // Full-precision signed product of sign-extended operands, rescaled back to Q format.
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    assign prod    = $signed({{WIDTH{t[WIDTH-1]}}, t}) * $signed({{WIDTH{x[WIDTH-1]}}, x});
    assign prod_sh = prod >>> FRAC;

    // One guard bit is enough to see accumulator overflow for a single add/subtract.
    logic [WIDTH:0] sum;
    assign sum = bus.mode ? ({r[WIDTH-1], r} - {t[WIDTH-1], t})
                          : ({r[WIDTH-1], r} + {t[WIDTH-1], t});

    // Upper product bits and the guard bit only matter when saturating.
    logic unused_bits;
    assign unused_bits = ^{prod_sh[2*WIDTH-1:WIDTH], sum[WIDTH]};

`ifdef SERIES_SAT_EN
    logic prod_ovf;
    logic sum_ovf;
    // Product overflows when the discarded high bits are not a sign extension of the kept MSB.
    assign prod_ovf = (|prod_sh[2*WIDTH-1:WIDTH-1]) && !(&prod_sh[2*WIDTH-1:WIDTH-1]);
    assign sum_ovf  = sum[WIDTH] ^ sum[WIDTH-1];

    // Clamp product and accumulator to the signed range on overflow.
    always_comb begin
        prod_val = prod_sh[WIDTH-1:0];
        sum_val  = sum[WIDTH-1:0];
        if (prod_ovf) prod_val = prod_sh[2*WIDTH-1] ? SMIN : SMAX;
        if (sum_ovf)  sum_val  = sum[WIDTH] ? SMIN : SMAX;
    end
`else
    // Plain two's-complement wrap: keep the low WIDTH bits.
    always_comb begin
        prod_val = prod_sh[WIDTH-1:0];
        sum_val  = sum[WIDTH-1:0];
    end
`endif

    // Term mux: next value for t as selected by the controller.
    always_comb begin
        term = t;
        case (sel)
            3'b000:  term = prod_val;
            3'b001:  term = {t[WIDTH-1], t[WIDTH-1:1]};
            3'b010:  term = -t;
            3'b011:  term = x;
            3'b100:  term = y;
            default: term = t;
        endcase
    end

    // Register transfers; init commands take priority over load/count on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
            t <= '0;
            r <= '0;
            c <= '0;
        end else begin
            if (bus.ld_x) x <= bus.x_in;
            if (bus.ld_y) y <= bus.y_in;

            if (bus.initt)     t <= ONE;
            else if (bus.ld_t) t <= term;

            if (bus.initr)     r <= '0;
            else if (bus.ld_r) r <= sum_val;

            if (bus.initc)                  c <= '0;
            else if (bus.cnt && (c != CMAX)) c <= c + 1'b1;
        end
    end

    // Loop-exit flag: |t| at WIDTH+1 bits so the most negative t still has a valid magnitude.
    logic [WIDTH:0] t_abs;
    logic           mag_below;
    logic           cnt_done;
    assign t_abs     = t[WIDTH-1] ? -{1'b1, t} : {1'b0, t};
    assign mag_below = $signed(t_abs) < $signed({y[WIDTH-1], y});
    assign cnt_done  = {1'b0, c} >= (CNT_W+1)'(MAX_ITER);

    assign bus.lt     = mag_below || cnt_done;
    assign bus.result = r;
    assign bus.count  = c;

endmodule

// File: tb/tb_series_datapath.sv
module tb_series_datapath;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    series_datapath_if #(.WIDTH(16), .CNT_W(4)) bus ();

    series_datapath #(
        .WIDTH(16), .FRAC(8), .CNT_W(4), .MAX_ITER(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference state as plain signed integers.
    int mx, my, mt, mr, mc;

    function automatic int sx(logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap16(longint v);
        longint m;
        m = v & 64'hFFFF;
        return (m >= 32768) ? int'(m - 65536) : int'(m);
    endfunction

    function automatic int fix16(longint v);
`ifdef SERIES_SAT_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        return wrap16(v);
`endif
    endfunction

    function automatic int exp_lt();
        int a;
        a = (mt < 0) ? -mt : mt;
        return ((a < my) || (mc >= 15)) ? 1 : 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: next state from pre-edge state using plain arithmetic.
    always @(posedge clk or negedge rst) begin : model_upd
        int     term, nt, nr, nc;
        longint p;
        if (!rst) begin
            mx = 0; my = 0; mt = 0; mr = 0; mc = 0;
        end else begin
            case ({bus.s2, bus.s1, bus.s0})
                3'd0: begin
                    p    = longint'(mt) * longint'(mx);
                    term = fix16(p >>> 8);
                end
                3'd1:    term = mt >>> 1;
                3'd2:    term = wrap16(-longint'(mt));
                3'd3:    term = mx;
                3'd4:    term = my;
                default: term = mt;
            endcase
            nt = bus.initt ? 256 : (bus.ld_t ? term : mt);
            nr = bus.initr ? 0 : (bus.ld_r ? fix16(bus.mode ? longint'(mr) - mt
                                                            : longint'(mr) + mt) : mr);
            nc = bus.initc ? 0 : (bus.cnt ? ((mc < 15) ? mc + 1 : 15) : mc);
            if (bus.ld_x) mx = sx(bus.x_in);
            if (bus.ld_y) my = sx(bus.y_in);
            mt = nt;
            mr = nr;
            mc = nc;
        end
    end

    // Continuous comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("cmp_result", sx(bus.result), mr);
            chk("cmp_count", int'(bus.count), mc);
            chk("cmp_lt", int'(bus.lt), exp_lt());
        end
    end

    task automatic clr();
        bus.initt = 0; bus.initr = 0; bus.initc = 0;
        bus.ld_x  = 0; bus.ld_y  = 0; bus.ld_t  = 0; bus.ld_r = 0;
        bus.cnt   = 0; bus.mode  = 0;
        bus.s2 = 0; bus.s1 = 0; bus.s0 = 0;
    endtask

    task automatic set_sel(int s);
        bus.s2 = s[2]; bus.s1 = s[1]; bus.s0 = s[0];
    endtask

    // One clock: commands presented before the edge, results sampled 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
        clr();
    endtask

    logic [15:0] e16;

    initial begin
        clr();
        bus.x_in = '0;
        bus.y_in = '0;

        // Reset state.
        #12;
        chk("reset_result", sx(bus.result), 0);
        chk("reset_count", int'(bus.count), 0);
        chk("reset_lt", int'(bus.lt), 0);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // Multiply path: x=0.5, t=1.0, then t*=x twice.
        bus.ld_x = 1; bus.x_in = 16'h0080; bus.initt = 1; bus.initr = 1; cyc();
        bus.ld_r = 1; cyc();
        chk("mul_t0", sx(bus.result), 'h100);
        bus.initr = 1; bus.ld_t = 1; set_sel(0); cyc();
        chk("mul_model_t1", mt, 'h80);
        bus.ld_r = 1; cyc();
        chk("mul_t1", sx(bus.result), 'h80);
        bus.initr = 1; bus.ld_t = 1; set_sel(0); cyc();
        bus.ld_r = 1; cyc();
        chk("mul_t2", sx(bus.result), 'h40);

        // Accumulate add, add, subtract.
        bus.initt = 1; bus.initr = 1; cyc();
        bus.ld_r = 1; cyc();
        chk("acc_1", sx(bus.result), 'h100);
        bus.ld_r = 1; cyc();
        chk("acc_2", sx(bus.result), 'h200);
        bus.ld_r = 1; bus.mode = 1; cyc();
        chk("acc_3", sx(bus.result), 'h100);

        // Same-edge ld_t and ld_r: r takes the old t.
        bus.initt = 1; bus.initr = 1; cyc();
        bus.ld_t = 1; set_sel(1); bus.ld_r = 1; cyc();
        chk("same_edge_r", sx(bus.result), 'h100);
        chk("same_edge_model_t", mt, 'h80);
        bus.ld_r = 1; cyc();
        chk("same_edge_r2", sx(bus.result), 'h180);

        // Loop-exit flag by magnitude, then by count.
        bus.ld_y = 1; bus.y_in = 16'h0010; bus.ld_x = 1; bus.x_in = 16'h0020; bus.initc = 1; cyc();
        bus.ld_t = 1; set_sel(3); cyc();
        chk("lt_t20", int'(bus.lt), 0);
        bus.ld_x = 1; bus.x_in = 16'h0008; cyc();
        bus.ld_t = 1; set_sel(3); cyc();
        chk("lt_t08", int'(bus.lt), 1);
        bus.ld_x = 1; bus.x_in = 16'hFFF0; cyc();
        bus.ld_t = 1; set_sel(3); cyc();
        chk("lt_tneg10", int'(bus.lt), 0);
        for (int i = 0; i < 15; i++) begin
            bus.cnt = 1; cyc();
            chk("cnt_count", int'(bus.count), i + 1);
            chk("cnt_lt", int'(bus.lt), (i == 14) ? 1 : 0);
        end
        for (int i = 0; i < 2; i++) begin
            bus.cnt = 1; cyc();
            chk("cnt_sat", int'(bus.count), 15);
        end

        // Accumulator overflow.
        bus.ld_x = 1; bus.x_in = 16'h7F00; cyc();
        bus.ld_t = 1; set_sel(3); bus.initr = 1; cyc();
        bus.ld_r = 1; cyc();
        chk("ovf_r_pre", sx(bus.result), 'h7F00);
        bus.ld_x = 1; bus.x_in = 16'h0200; cyc();
        bus.ld_t = 1; set_sel(3); cyc();
        bus.ld_r = 1; cyc();
`ifdef SERIES_SAT_EN
        e16 = 16'h7FFF;
`else
        e16 = 16'h8100;
`endif
        chk("ovf_r", sx(bus.result), sx(e16));

        // Product overflow: t=0x0200 (2.0) times x=0x7F00 (127.0).
        bus.ld_x = 1; bus.x_in = 16'h7F00; cyc();
        bus.ld_t = 1; set_sel(0); bus.initr = 1; cyc();
        bus.ld_r = 1; cyc();
`ifdef SERIES_SAT_EN
        e16 = 16'h7FFF;
`else
        e16 = 16'hFE00;
`endif
        chk("ovf_prod", sx(bus.result), sx(e16));

        // Asynchronous reset mid-run with r=0x0123, c=5.
        bus.ld_x = 1; bus.x_in = 16'h0123; bus.initc = 1; cyc();
        bus.ld_t = 1; set_sel(3); bus.initr = 1; cyc();
        bus.ld_r = 1; bus.cnt = 1; cyc();
        for (int i = 0; i < 4; i++) begin
            bus.cnt = 1; cyc();
        end
        chk("pre_rst_result", sx(bus.result), 'h123);
        chk("pre_rst_count", int'(bus.count), 5);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_result", sx(bus.result), 0);
        chk("async_rst_count", int'(bus.count), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Randomized commands with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b0;
                #1;
                chk("rand_rst_result", sx(bus.result), 0);
                chk("rand_rst_count", int'(bus.count), 0);
                @(negedge clk);
                rst = 1'b1;
                #1;
            end
            bus.initt = ($urandom_range(0, 15) == 0);
            bus.initr = ($urandom_range(0, 15) == 0);
            bus.initc = ($urandom_range(0, 15) == 0);
            bus.ld_x  = ($urandom_range(0, 3) == 0);
            bus.ld_y  = ($urandom_range(0, 3) == 0);
            bus.ld_t  = $urandom_range(0, 1);
            bus.ld_r  = $urandom_range(0, 1);
            bus.cnt   = ($urandom_range(0, 2) == 0);
            bus.mode  = $urandom_range(0, 1);
            set_sel(int'($urandom_range(0, 7)));
            bus.x_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0300))
                                                    : 16'($urandom);
            bus.y_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0200))
                                                    : 16'($urandom);
            cyc();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
